// File: rtl/fpu_pkg.sv
// Shared FPU front-end types: operand widths, alignment FSM states and the
// unpacked single-precision operand.
package fpu_pkg;

    localparam int MANT_W      = 24;
    localparam int EXP_W       = 8;
    localparam int SHIFT_FLUSH = 24;

    typedef enum logic [1:0] {IDLE, CMP, SHIFT, HOLD} state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  eff_exp;
        logic [MANT_W-1:0] mant;
    } operand_t;

    // Denormals take effective exponent 1 and no hidden bit.
    function automatic operand_t unpack_op(input logic [31:0] x);
        operand_t o;
        o.sign    = x[31];
        o.eff_exp = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        o.mant    = {(x[30:23] != 8'd0), x[22:0]};
        return o;
    endfunction

endpackage

// File: rtl/shifter.sv
// Mantissa right shifter; BY is two's complement and shifts by its magnitude.
module shifter
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] IN,
    input  logic [7:0]        BY,
    output logic [MANT_W-1:0] OUT
);

    logic [7:0] mag;

    assign mag = BY[7] ? (~BY + 8'd1) : BY;
    assign OUT = IN >> mag;

endmodule

// File: rtl/fpu_align_ctrl.sv
// Operand alignment sequencer: capture, compare/swap, shift+sticky, then hold
// the aligned pair until the add/normalize stage accepts it.
module fpu_align_ctrl
    import fpu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [EXP_W-1:0]  EXP_OUT,
    output logic [MANT_W-1:0] MANT_BIG,
    output logic [MANT_W-1:0] MANT_SMALL,
    output logic              STICKY,
    output logic              SIGN_BIG,
    output logic              SIGN_SMALL,
    output logic              SWAPPED,
    output logic              SPECIAL
);

    state_t state, state_n;

    logic [31:0]       a_q, b_q;
    logic [8:0]        d_q;
    logic [MANT_W-1:0] small_q;
    logic [EXP_W-1:0]  exp_big_q;

    operand_t          op_a, op_b;
    logic [8:0]        d;
    logic              a_big;
    logic [8:0]        abs_d;
    logic              flush;
    logic [MANT_W-1:0] mask;
    logic [MANT_W-1:0] shifted;
    logic              sticky_n;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = !RST;
                if (IN_VALID) state_n = CMP;
            end
            CMP:   state_n = SHIFT;
            SHIFT: state_n = HOLD;
            HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign op_a  = unpack_op(a_q);
    assign op_b  = unpack_op(b_q);
    assign d     = {1'b0, op_a.eff_exp} - {1'b0, op_b.eff_exp};
    assign a_big = ($signed(d) > 9'sd0) || ((d == 9'd0) && (op_a.mant >= op_b.mant));

    // Flush covers exponent gaps the mantissa cannot represent, including
    // the >127 gaps that would alias in the 8-bit BY field.
    assign abs_d    = d_q[8] ? (~d_q + 9'd1) : d_q;
    assign flush    = abs_d >= 9'(SHIFT_FLUSH);
    assign mask     = (MANT_W'(1) << abs_d) - MANT_W'(1);
    assign sticky_n = flush ? |small_q : |(small_q & mask);

    shifter u_shifter (
        .IN  (small_q),
        .BY  (d_q[7:0]),
        .OUT (shifted)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q        <= '0;
            b_q        <= '0;
            d_q        <= '0;
            small_q    <= '0;
            exp_big_q  <= '0;
            EXP_OUT    <= '0;
            MANT_BIG   <= '0;
            MANT_SMALL <= '0;
            STICKY     <= 1'b0;
            SIGN_BIG   <= 1'b0;
            SIGN_SMALL <= 1'b0;
            SWAPPED    <= 1'b0;
            SPECIAL    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (IN_VALID) begin
                    a_q <= A;
                    b_q <= B;
                end
                CMP: begin
                    d_q        <= d;
                    SWAPPED    <= !a_big;
                    MANT_BIG   <= a_big ? op_a.mant : op_b.mant;
                    small_q    <= a_big ? op_b.mant : op_a.mant;
                    SIGN_BIG   <= a_big ? op_a.sign : op_b.sign;
                    SIGN_SMALL <= a_big ? op_b.sign : op_a.sign;
                    exp_big_q  <= a_big ? op_a.eff_exp : op_b.eff_exp;
                    SPECIAL    <= (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
                end
                SHIFT: begin
                    MANT_SMALL <= flush ? '0 : shifted;
                    STICKY     <= sticky_n;
                    EXP_OUT    <= exp_big_q;
                end
                default: ;
            endcase
        end
    end

endmodule
